// File: rtl/sakebi_eth_pkg.sv
// Shared Ethernet framing constants and the TX state encoding for the sakebi MAC.
package sakebi_eth_pkg;

  localparam int          PREAMBLE_DIBITS = 31;
  localparam logic [1:0]  PREAMBLE_DIBIT  = 2'b01;
  localparam logic [1:0]  SFD_DIBIT       = 2'b11;
  localparam int          MIN_FRAME_BYTES = 60;
  localparam logic [31:0] CRC32_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_SFD      = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_PAD      = 3'd4;
  localparam logic [2:0] ST_FCS      = 3'd5;
  localparam logic [2:0] ST_IPG      = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_PREAMBLE = ST_PREAMBLE,
    S_SFD      = ST_SFD,
    S_DATA     = ST_DATA,
    S_PAD      = ST_PAD,
    S_FCS      = ST_FCS,
    S_IPG      = ST_IPG
  } tx_state_e;

  // Dibit idx of a byte, LSB pair first as it goes on the RMII wire.
  function automatic logic [1:0] dibit_sel(input logic [7:0] b, input logic [1:0] idx);
    return b[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/sakebi_crc32_byte.sv
// One-byte step of the reflected CRC-32 (Ethernet FCS), purely combinational.
// Shared by the TX FCS generator and the RX FCS checker.
module sakebi_crc32_byte
  import sakebi_eth_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  always_comb begin
    logic [31:0] w_c;
    w_c = i_crc;
    for (int i = 0; i < 8; i++) begin
      if (w_c[0] ^ i_data[i]) w_c = (w_c >> 1) ^ CRC32_POLY;
      else                    w_c = w_c >> 1;
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/sakebi_rmii_tx.sv
// RMII 100 Mb/s transmitter: AXIS bytes in, preamble/SFD + data + pad + FCS out, one dibit per REF_CLK.
// Wire outputs lag the state register by one cycle; TREADY is a pure state decode, one byte per 4 cycles.
module sakebi_rmii_tx
  import sakebi_eth_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PAD_EN     = 1,
  parameter int IPG_DIBITS = 48
) (
  input  logic                  i_rmii_REF_CLK,
  input  logic                  i_axis_ARESETn,
  input  logic                  i_axis_TVALID,
  output logic                  o_axis_TREADY,
  input  logic [DATA_WIDTH-1:0] i_axis_TDATA,
  input  logic                  i_axis_TLAST,
  output logic                  o_rmii_TX_EN,
  output logic [1:0]            o_rmii_TXD,
  output logic                  o_tx_busy,
  output logic                  o_tx_underrun
);

  // IPG counter loads are chosen so the idle gap seen on the wire, including the
  // IDLE cycle that samples TVALID, is exactly IPG_DIBITS (needs IPG_DIBITS >= 3).
  localparam logic [15:0] IPG_LOAD_FCS   = 16'(IPG_DIBITS - 2);
  localparam logic [15:0] IPG_LOAD_ABORT = 16'(IPG_DIBITS - 3);

  tx_state_e   r_state, w_next;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [1:0]  r_dibit, w_dibit_nxt;
  logic [7:0]  r_byte, w_byte_nxt;
  logic        r_last, w_last_nxt;
  logic [15:0] r_byte_cnt;
  logic [31:0] r_crc;
  logic        r_tx_en, r_busy, r_underrun;
  logic [1:0]  r_txd;

  logic        w_latch, w_abort, w_tready, w_tx_en, w_pad_more;
  logic [1:0]  w_txd;
  logic [7:0]  w_crc_din;
  logic [31:0] w_crc_step, w_fcs;

  sakebi_crc32_byte u_crc (
    .i_crc  (r_crc),
    .i_data (w_crc_din),
    .o_crc  (w_crc_step)
  );

  assign w_fcs      = ~r_crc;
  assign w_pad_more = (PAD_EN != 0) && (r_byte_cnt < 16'(MIN_FRAME_BYTES));

  always_comb begin
    w_next      = r_state;
    w_cnt_nxt   = r_cnt;
    w_dibit_nxt = r_dibit;
    w_byte_nxt  = r_byte;
    w_last_nxt  = r_last;
    w_latch     = 1'b0;
    w_crc_din   = i_axis_TDATA;
    w_abort     = 1'b0;
    w_tready    = 1'b0;
    w_tx_en     = 1'b0;
    w_txd       = 2'b00;
    unique case (r_state)
      S_IDLE: begin
        if (i_axis_TVALID) begin
          w_next    = S_PREAMBLE;
          w_cnt_nxt = '0;
        end
      end
      S_PREAMBLE: begin
        w_tx_en = 1'b1;
        w_txd   = PREAMBLE_DIBIT;
        if (r_cnt == 16'(PREAMBLE_DIBITS - 1)) w_next = S_SFD;
        else                                   w_cnt_nxt = r_cnt + 16'd1;
      end
      S_SFD: begin
        w_tready = 1'b1;
        w_tx_en  = 1'b1;
        w_txd    = SFD_DIBIT;
        if (i_axis_TVALID) begin
          w_latch     = 1'b1;
          w_byte_nxt  = i_axis_TDATA;
          w_last_nxt  = i_axis_TLAST;
          w_dibit_nxt = 2'd0;
          w_next      = S_DATA;
        end else begin
          w_abort = 1'b1;
        end
      end
      S_DATA, S_PAD: begin
        w_tx_en     = 1'b1;
        w_txd       = dibit_sel(r_byte, r_dibit);
        w_dibit_nxt = r_dibit + 2'd1;
        if (r_dibit == 2'd3) begin
          if (r_state == S_DATA && !r_last) begin
            w_tready = 1'b1;
            if (i_axis_TVALID) begin
              w_latch    = 1'b1;
              w_byte_nxt = i_axis_TDATA;
              w_last_nxt = i_axis_TLAST;
            end else begin
              w_abort = 1'b1;
            end
          end else if (w_pad_more) begin
            // Pad bytes enter the CRC exactly like payload bytes.
            w_next     = S_PAD;
            w_latch    = 1'b1;
            w_crc_din  = 8'h00;
            w_byte_nxt = 8'h00;
          end else begin
            w_next    = S_FCS;
            w_cnt_nxt = '0;
          end
        end
      end
      S_FCS: begin
        w_tx_en = 1'b1;
        w_txd   = w_fcs[{r_cnt[3:0], 1'b0} +: 2];
        if (r_cnt[3:0] == 4'd15) begin
          w_next    = S_IPG;
          w_cnt_nxt = IPG_LOAD_FCS;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_IPG: begin
        if (r_cnt == 16'd0) w_next = S_IDLE;
        else                w_cnt_nxt = r_cnt - 16'd1;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) begin
      w_next    = S_IPG;
      w_cnt_nxt = IPG_LOAD_ABORT;
      w_tx_en   = 1'b0;
      w_txd     = 2'b00;
    end
  end

  always_ff @(posedge i_rmii_REF_CLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dibit    <= '0;
      r_byte     <= '0;
      r_last     <= 1'b0;
      r_byte_cnt <= '0;
      r_crc      <= CRC32_INIT;
      r_tx_en    <= 1'b0;
      r_txd      <= 2'b00;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_nxt;
      r_dibit    <= w_dibit_nxt;
      r_byte     <= w_byte_nxt;
      r_last     <= w_last_nxt;
      r_tx_en    <= w_tx_en;
      r_txd      <= w_txd;
      r_busy     <= (w_next != S_IDLE);
      r_underrun <= w_abort;
      if (r_state == S_IDLE) begin
        r_crc      <= CRC32_INIT;
        r_byte_cnt <= '0;
      end else if (w_latch) begin
        r_crc <= w_crc_step;
        if (r_byte_cnt != 16'hFFFF) r_byte_cnt <= r_byte_cnt + 16'd1;
      end
    end
  end

  assign o_axis_TREADY = w_tready;
  assign o_rmii_TX_EN  = r_tx_en;
  assign o_rmii_TXD    = r_txd;
  assign o_tx_busy     = r_busy;
  assign o_tx_underrun = r_underrun;

endmodule

// File: tb/tb_sakebi_rmii_tx.sv
// Directed bench for sakebi_rmii_tx: one instance without padding, one with.
`timescale 1ns/1ps
module tb_sakebi_rmii_tx;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic            arst_n;
  logic [1:0]      tvalid, tlast, tready, tx_en, busy, underrun;
  logic [1:0][7:0] tdata;
  logic [1:0][1:0] txd;

  sakebi_rmii_tx #(.DATA_WIDTH(8), .PAD_EN(0), .IPG_DIBITS(48)) u_dut_nopad (
    .i_rmii_REF_CLK (clk),
    .i_axis_ARESETn (arst_n),
    .i_axis_TVALID  (tvalid[0]),
    .o_axis_TREADY  (tready[0]),
    .i_axis_TDATA   (tdata[0]),
    .i_axis_TLAST   (tlast[0]),
    .o_rmii_TX_EN   (tx_en[0]),
    .o_rmii_TXD     (txd[0]),
    .o_tx_busy      (busy[0]),
    .o_tx_underrun  (underrun[0])
  );

  sakebi_rmii_tx #(.DATA_WIDTH(8), .PAD_EN(1), .IPG_DIBITS(48)) u_dut_pad (
    .i_rmii_REF_CLK (clk),
    .i_axis_ARESETn (arst_n),
    .i_axis_TVALID  (tvalid[1]),
    .o_axis_TREADY  (tready[1]),
    .i_axis_TDATA   (tdata[1]),
    .i_axis_TLAST   (tlast[1]),
    .o_rmii_TX_EN   (tx_en[1]),
    .o_rmii_TXD     (txd[1]),
    .o_tx_busy      (busy[1]),
    .o_tx_underrun  (underrun[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Trace entry: {tvalid, busy, underrun, tready, tx_en, txd[1:0]}
  logic [6:0] trace[$];
  int         mon_sel = 0;
  bit         rec = 1'b0;
  always @(negedge clk)
    if (rec) trace.push_back({tvalid[mon_sel], busy[mon_sel], underrun[mon_sel],
                              tready[mon_sel], tx_en[mon_sel], txd[mon_sel]});

  logic [7:0] sb[$];
  bit         sl[$];
  logic [7:0] exp_b[$];
  int         run_start, run_end;

  function automatic logic [31:0] fcs_model();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (exp_b[k])
      for (int j = 0; j < 8; j++)
        if (c[0] ^ exp_b[k][j]) c = (c >> 1) ^ 32'hEDB88320;
        else                    c = c >> 1;
    return ~c;
  endfunction

  function automatic logic [1:0] dib(input int i);
    if (i < trace.size()) return trace[i][1:0];
    return 2'b00;
  endfunction

  function automatic int count_bit(input int b);
    int n = 0;
    foreach (trace[i]) if (trace[i][b]) n++;
    return n;
  endfunction

  // Streams sb/sl; drop_idx: withhold TVALID on that byte's first TREADY cycle, then resume at resume_idx.
  task automatic drive(input int sel, input int drop_idx, input int resume_idx);
    int i = 0;
    int guard = 0;
    bit rdy;
    tdata[sel] = sb[0]; tlast[sel] = sl[0]; tvalid[sel] = 1'b1;
    while (i < sb.size() && guard < 4000) begin
      @(negedge clk);
      rdy = tready[sel];
      guard++;
      if (rdy && i == drop_idx) begin
        tvalid[sel] = 1'b0;
        @(posedge clk); #1;
        i = resume_idx;
        if (i < sb.size()) begin
          tvalid[sel] = 1'b1; tdata[sel] = sb[i]; tlast[sel] = sl[i];
        end
      end else begin
        @(posedge clk); #1;
        if (rdy) begin
          i++;
          if (i < sb.size()) begin tdata[sel] = sb[i]; tlast[sel] = sl[i]; end
        end
      end
    end
    tvalid[sel] = 1'b0; tlast[sel] = 1'b0;
    check_val("drive_done", (i >= sb.size()), 1);
  endtask

  task automatic check_frame(input string nm, inout int idx, input int n_bytes,
                             input int exp_len, input bit has_fcs, output int gap);
    int p, len, ok, nb, q;
    logic [7:0]  b;
    logic [31:0] f;
    p = idx;
    while (p < trace.size() && !trace[p][2]) p++;
    len = 0; nb = 0;
    while (p + len < trace.size() && trace[p + len][2]) begin
      if (!trace[p + len][5]) nb++;
      len++;
    end
    run_start = p;
    run_end   = p + len;
    check_val({nm, "_len"}, len, exp_len);
    check_val({nm, "_busy_low_in_frame"}, nb, 0);
    ok = 0;
    for (int k = 0; k < 31; k++) if (p + k < trace.size() && trace[p + k][2:0] == 3'b101) ok++;
    check_val({nm, "_preamble"}, ok, 31);
    check_val({nm, "_sfd"}, dib(p + 31), 2'b11);
    for (int k = 0; k < n_bytes; k++) begin
      q = p + 32 + 4 * k;
      b = {dib(q + 3), dib(q + 2), dib(q + 1), dib(q)};
      check_val($sformatf("%s_byte%0d", nm, k), b, exp_b[k]);
    end
    if (has_fcs) begin
      f = '0;
      for (int j = 0; j < 16; j++) f[2 * j +: 2] = dib(p + 32 + 4 * n_bytes + j);
      check_val({nm, "_fcs"}, f, fcs_model());
    end
    gap = 0;
    q = p + len;
    while (q < trace.size() && !trace[q][2]) begin gap++; q++; end
    idx = q;
  endtask

  initial begin
    int idx, gap, s, r;
    logic [31:0] fa;
    arst_n = 1'b0;
    tvalid = '0; tlast = '0; tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_tx_en", tx_en, 0);
    check_val("rst_txd", txd, 0);
    check_val("rst_tready", tready, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_underrun", underrun, 0);
    @(negedge clk) arst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // "123456789", no padding: CRC check value gives FCS bytes 26 39 F4 CB
    sb = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    sl = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    mon_sel = 0; trace.delete(); rec = 1'b1;
    drive(0, -1, 0);
    repeat (150) @(posedge clk);
    #1 rec = 1'b0;
    exp_b = sb; idx = 0;
    check_frame("a", idx, 9, 84, 1'b1, gap);
    fa = '0;
    for (int j = 0; j < 16; j++) fa[2 * j +: 2] = dib(run_start + 68 + j);
    check_val("a_fcs_check_value", fa, 32'hCBF43926);
    check_val("a_gap_ge48", (gap >= 48), 1);
    check_val("a_tready_cycles", count_bit(3), 9);
    check_val("a_busy_end", busy[0], 0);

    // 1-byte frame with padding to 60 bytes
    sb = '{8'hAA}; sl = '{1};
    mon_sel = 1; trace.delete(); rec = 1'b1;
    drive(1, -1, 0);
    repeat (400) @(posedge clk);
    #1 rec = 1'b0;
    exp_b = '{8'hAA};
    repeat (59) exp_b.push_back(8'h00);
    idx = 0;
    check_frame("b", idx, 60, 288, 1'b1, gap);
    check_val("b_tready_cycles", count_bit(3), 1);

    // Back-to-back frames, TVALID held high across the gap
    sb = '{8'h10, 8'h20, 8'h30, 8'h40, 8'hA5, 8'h5A, 8'hC3};
    sl = '{0, 0, 0, 1, 0, 0, 1};
    mon_sel = 0; trace.delete(); rec = 1'b1;
    drive(0, -1, 0);
    repeat (200) @(posedge clk);
    #1 rec = 1'b0;
    exp_b = '{8'h10, 8'h20, 8'h30, 8'h40}; idx = 0;
    check_frame("c1", idx, 4, 64, 1'b1, gap);
    check_val("c_gap", gap, 48);
    exp_b = '{8'hA5, 8'h5A, 8'hC3};
    check_frame("c2", idx, 3, 60, 1'b1, gap);

    // Underrun on the 5th byte, then a 2-byte frame waiting with TVALID high
    sb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hE1, 8'hE2};
    sl = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    trace.delete(); rec = 1'b1;
    drive(0, 4, 8);
    repeat (200) @(posedge clk);
    #1 rec = 1'b0;
    exp_b = '{8'h01, 8'h02, 8'h03}; idx = 0;
    check_frame("d1", idx, 3, 47, 1'b0, gap);
    check_val("d_gap", gap, 48);
    check_val("d_underrun_pulses", count_bit(4), 1);
    r = -1;
    foreach (trace[i]) if (trace[i][4] && r < 0) r = i;
    check_val("d_underrun_pos", r, run_end);
    exp_b = '{8'hE1, 8'hE2};
    check_frame("d2", idx, 2, 56, 1'b1, gap);

    // Single TLAST byte presented in IDLE, no padding
    sb = '{8'h5C}; sl = '{1};
    trace.delete(); rec = 1'b1;
    @(posedge clk); #1;
    drive(0, -1, 0);
    repeat (120) @(posedge clk);
    #1 rec = 1'b0;
    s = -1;
    foreach (trace[i]) if (trace[i][6] && s < 0) s = i;
    r = -1;
    foreach (trace[i]) if (trace[i][3] && r < 0) r = i;
    exp_b = '{8'h5C}; idx = 0;
    check_frame("e", idx, 1, 52, 1'b1, gap);
    check_val("e_preamble_start", run_start - s, 2);
    check_val("e_accept_in_sfd", r - run_start, 30);

    // Asynchronous reset while streaming 0xFF bytes mid-DATA
    tdata[0] = 8'hFF; tlast[0] = 1'b0; tvalid[0] = 1'b1;
    repeat (45) @(posedge clk);
    #3;
    check_val("f_en_before_reset", tx_en[0], 1);
    arst_n = 1'b0;
    #2;
    check_val("f_rst_tx_en", tx_en[0], 0);
    check_val("f_rst_txd", txd[0], 0);
    check_val("f_rst_busy", busy[0], 0);
    tvalid[0] = 1'b0;
    @(negedge clk) arst_n = 1'b1;
    trace.delete(); rec = 1'b1;
    repeat (30) @(posedge clk);
    #1 rec = 1'b0;
    check_val("f_post_en_cycles", count_bit(2), 0);
    check_val("f_post_busy_cycles", count_bit(5), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
